moore_run_detector: RTL and testbench

- Parametrised Moore sequence detector: the successor to the two-flip-flop W/Zout Moore FSM.
- Asserts Zout after RUN_LEN consecutive samples of W=1, rather than a fixed hard-coded sequence.
- Adds a runtime overlap mode, a synchronous clear, and an optional saturating hit counter.
- Used standalone on a board input or as a qualifier stage ahead of other FSMs in the lab designs.

---
 rtl/moore_run_detector.sv | 48 ++++
 tb/tb_moore_run_detector.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/moore_run_detector.sv
// moore_run_detector: Zout rises once RUN_LEN consecutive W=1 samples have been seen; define MOORE_HIT_CNT_EN to add a saturating hit_count
module moore_run_detector #(
  parameter int RUN_LEN   = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 W,
  input  logic                 overlap,
  input  logic                 clr,
`ifdef MOORE_HIT_CNT_EN
  output logic [CNT_WIDTH-1:0] hit_count,
`endif
  output logic                 Zout
);
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam logic [RW-1:0] R_MAX = RW'(RUN_LEN);
  localparam logic [RW-1:0] R_ONE = RW'(1);
  logic [RW-1:0] r_q, r_d;
  assign Zout = (r_q == R_MAX);
  // next run length: W=0, clr or an illegal encoding restarts; a full run holds or restarts at 1
  always_comb begin
    r_d = (clr || !W) ? '0
        : (r_q < R_MAX) ? r_q + R_ONE
        : (r_q == R_MAX) ? (overlap ? R_MAX : R_ONE)
        : '0;
  end
  // run length register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) r_q <= '0;
    else          r_q <= r_d;
  end
`ifdef MOORE_HIT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 hit;
  assign hit_count = cnt_q;
  // a detection is entering the full state, or re-arming it without overlap; count saturates
  always_comb begin
    hit   = !clr && (r_d == R_MAX) && (!Zout || !overlap);
    cnt_d = clr ? '0 : (hit && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end
  // hit counter register
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_moore_run_detector.sv
// tb_moore_run_detector: directed checks of the run detector at RUN_LEN=3 and RUN_LEN=1/CNT_WIDTH=2
module tb_moore_run_detector;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic W = 1'b0;
  logic overlap = 1'b1;
  logic clr = 1'b0;
  logic z3, z1;
  int n_checks = 0;
  int n_fails = 0;
`ifdef MOORE_HIT_CNT_EN
  logic [7:0] hc3;
  logic [1:0] hc1;
`endif

  always #5 clk = ~clk;

  moore_run_detector #(.RUN_LEN(3), .CNT_WIDTH(8)) u3 (
    .clk(clk), .reset_n(reset_n), .W(W), .overlap(overlap), .clr(clr),
`ifdef MOORE_HIT_CNT_EN
    .hit_count(hc3),
`endif
    .Zout(z3)
  );

  moore_run_detector #(.RUN_LEN(1), .CNT_WIDTH(2)) u1 (
    .clk(clk), .reset_n(reset_n), .W(W), .overlap(overlap), .clr(clr),
`ifdef MOORE_HIT_CNT_EN
    .hit_count(hc1),
`endif
    .Zout(z1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic w);
    W = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1'b0);
    clr = 1'b0;
  endtask

  initial begin
    logic [5:0] e6;
    logic [6:0] e7;
    logic [5:0] w6;
    logic [1:0] h6 [6];
    tick(1'b1);
    tick(1'b1);
    check("reset_z3", z3, 0);
    check("reset_z1", z1, 0);
`ifdef MOORE_HIT_CNT_EN
    check("reset_hc3", hc3, 0);
    check("reset_hc1", hc1, 0);
`endif
    reset_n = 1'b1;
    overlap = 1'b1;
    e6 = 6'b001110;
    for (int i = 0; i < 6; i++) begin
      tick(i < 5);
      check($sformatf("ovl_z3_%0d", i), z3, e6[5-i]);
    end
`ifdef MOORE_HIT_CNT_EN
    check("ovl_hc3", hc3, 1);
`endif
    do_clr();
`ifdef MOORE_HIT_CNT_EN
    check("clr_hc3", hc3, 0);
`endif
    overlap = 1'b0;
    e7 = 7'b0010010;
    for (int i = 0; i < 7; i++) begin
      tick(i < 6);
      check($sformatf("novl_z3_%0d", i), z3, e7[6-i]);
    end
`ifdef MOORE_HIT_CNT_EN
    check("novl_hc3", hc3, 2);
`endif
    do_clr();
    w6 = 6'b110111;
    e6 = 6'b000001;
    for (int i = 0; i < 6; i++) begin
      tick(w6[5-i]);
      check($sformatf("brk_z3_%0d", i), z3, e6[5-i]);
    end
`ifdef MOORE_HIT_CNT_EN
    check("brk_hc3", hc3, 1);
`endif
    do_clr();
    tick(1'b1);
    tick(1'b1);
    check("rst_mid_pre", z3, 0);
    reset_n = 1'b0;
    tick(1'b1);
    reset_n = 1'b1;
    check("rst_mid_edge", z3, 0);
    tick(1'b1);
    check("rst_mid_a", z3, 0);
    tick(1'b1);
    check("rst_mid_b", z3, 0);
`ifdef MOORE_HIT_CNT_EN
    check("rst_mid_hc3", hc3, 0);
`endif
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    clr = 1'b1;
    tick(1'b1);
    clr = 1'b0;
    check("clr_mid_edge", z3, 0);
    tick(1'b1);
    check("clr_mid_a", z3, 0);
    tick(1'b1);
    check("clr_mid_b", z3, 0);
`ifdef MOORE_HIT_CNT_EN
    check("clr_mid_hc3", hc3, 0);
`endif
    tick(1'b1);
    check("clr_mid_full", z3, 1);
    do_clr();
    overlap = 1'b0;
    h6 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      tick(1'b1);
      check($sformatf("sat_z1_%0d", i), z1, 1);
`ifdef MOORE_HIT_CNT_EN
      check($sformatf("sat_hc1_%0d", i), hc1, h6[i]);
`endif
    end
    tick(1'b0);
    check("sat_z1_end", z1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
